multicycle_control_unit: RTL and testbench

//  Moore FSM control for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder.

---
 rtl/mips_pkg.sv | 140 ++++++++++++++
 rtl/multicycle_control_unit.sv | 148 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, mux selects,
// trap causes, FSM states and the per-state control word decode.
package mips_pkg;

  localparam int unsigned OP_W = 6;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_LH    = 6'b100001;
  localparam opcode_t OP_LHU   = 6'b100101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       half;
    logic       half_unsigned;
    logic       retire;
    logic       trap;
  } ctrl_t;

  // Moore control word for a state; op is the opcode latched in DECODE.
  function automatic ctrl_t ctrl_decode(state_t s, opcode_t op);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = ALUSRCB_FOUR;
      end
      S_DECODE: begin
        c.alu_src_b = ALUSRCB_IMM_SH2;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        if (op == OP_RTYPE) begin
          c.alu_src_b = ALUSRCB_B;
          c.alu_op    = ALUOP_FUNCT;
        end else begin
          c.alu_src_b = ALUSRCB_IMM;
          c.alu_op    = ALUOP_ADD;
        end
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUSRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write     = 1'b1;
        c.mem_to_reg    = 1'b1;
        c.half          = (op == OP_LH) || (op == OP_LHU);
        c.half_unsigned = (op == OP_LHU);
        c.retire        = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = ALUSRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.retire        = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        c.retire    = 1'b1;
      end
      S_TRAP: begin
        c.trap = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory ready
// handshake, wait timeout and illegal-opcode trap.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter bit          HALF_EN     = 1'b1,
  parameter bit          JUMP_EN     = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       half,
  output logic       half_unsigned,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam bit               TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W:0]   TMO_V  = (CNT_W+1)'(MEM_TIMEOUT);

  state_t            state, state_n;
  opcode_t           op_q, op_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W:0]    cnt_inc;
  logic [1:0]        cause_q, cause_n;
  ctrl_t             ctrl_q;
  logic              in_wait;
  logic              tmo_hit;
  logic              zero_unused;

  // Branch resolution happens in the datapath via pc_write_cond; the flag is not needed here.
  assign zero_unused = zero;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign tmo_hit = TMO_EN && (cnt_inc == TMO_V);
  assign op_n    = (state == S_DECODE) ? opcode : op_q;

  // Next-state logic; mem_ready beats a timeout landing in the same cycle.
  always_comb begin
    state_n = state;
    cause_n = TRAP_NONE;
    cnt_n   = '0;
    unique case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_n = S_DECODE;
        end else if (tmo_hit) begin
          state_n = S_TRAP;
          cause_n = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_n = S_EXEC;
          OP_LW, OP_SW:      state_n = S_MEM_ADDR;
          OP_LH, OP_LHU:     state_n = HALF_EN ? S_MEM_ADDR : S_TRAP;
          OP_BEQ:            state_n = S_BRANCH;
          OP_J:              state_n = JUMP_EN ? S_JUMP : S_TRAP;
          default:           state_n = S_TRAP;
        endcase
        cause_n = TRAP_ILLEGAL;
      end
      S_EXEC:     state_n = (op_q == OP_RTYPE) ? S_R_WB : S_I_WB;
      S_MEM_ADDR: state_n = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_n = S_MEM_WB;
        end else if (tmo_hit) begin
          state_n = S_TRAP;
          cause_n = TRAP_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_n = S_FETCH;
        end else if (tmo_hit) begin
          state_n = S_TRAP;
          cause_n = TRAP_TIMEOUT;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_n = S_FETCH;
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
    if (in_wait && !mem_ready) begin
      cnt_n = cnt_inc[CNT_W-1:0];
    end
  end

  // State, latched opcode, wait counter, trap cause and the registered control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= OP_RTYPE;
      cnt     <= '0;
      cause_q <= TRAP_NONE;
      ctrl_q  <= ctrl_decode(S_FETCH, OP_RTYPE);
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt    <= cnt_n;
      ctrl_q <= ctrl_decode(state_n, op_n);
      if ((state_n == S_TRAP) && (state != S_TRAP)) begin
        cause_q <= cause_n;
      end
    end
  end

  // FETCH PC/IR loads and the store's retire follow mem_ready within the cycle.
  assign pc_write      = ctrl_q.pc_write | ((state == S_FETCH) & mem_ready);
  assign ir_write      = (state == S_FETCH) & mem_ready;
  assign retire        = ctrl_q.retire | ((state == S_MEM_WR) & mem_ready);
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign half          = ctrl_q.half;
  assign half_unsigned = ctrl_q.half_unsigned;
  assign trap          = ctrl_q.trap;
  assign trap_cause    = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-instruction expectations from
// a latency/count model, checked by a monitor on each retire or trap.
module tb_multicycle_control_unit;

  localparam int TMO = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;

  typedef struct {
    int        lat;
    bit        is_trap;
    int        cause;
    int        n_mrd;
    int        n_mwr;
    int        n_rw;
    int        n_pcw;
    int        n_irw;
    int        n_pwc;
    int        snap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, half, half_unsigned;
  logic       retire, trap;
  logic [1:0] alu_src_b, alu_op, pc_source, trap_cause;

  logic       rst2, rdy2;
  logic [5:0] op2;
  logic       pcw2, pwc2, iod2, mrd2, mwr2, irw2, rdst2, m2r2, rw2, asa2, hf2, hu2, ret2, trap2;
  logic [1:0] asb2, aop2, pcs2, tc2;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .half(half), .half_unsigned(half_unsigned),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_control_unit #(.HALF_EN(1'b0), .JUMP_EN(1'b0), .MEM_TIMEOUT(0), .CNT_W(5)) dut_nh (
    .clk(clk), .reset(rst2), .opcode(op2), .zero(zero), .mem_ready(rdy2),
    .pc_write(pcw2), .pc_write_cond(pwc2), .i_or_d(iod2),
    .mem_read(mrd2), .mem_write(mwr2), .ir_write(irw2),
    .reg_dst(rdst2), .mem_to_reg(m2r2), .reg_write(rw2),
    .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
    .pc_source(pcs2), .half(hf2), .half_unsigned(hu2),
    .retire(ret2), .trap(trap2), .trap_cause(tc2)
  );

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_LH, OP_LHU};
  endfunction

  function automatic bit is_mem(logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_LH, OP_LHU};
  endfunction

  // Snapshot bits: reg_dst, mem_to_reg, half, half_unsigned, i_or_d, alu_src_a, alu_src_b, alu_op, pc_source.
  function automatic exp_t model(logic [5:0] op, int fw, int mw);
    exp_t e;
    int   pre;
    e = '{default: 0};
    pre = fw + 3;
    if (fw >= TMO) begin
      e.is_trap = 1; e.cause = 2; e.lat = TMO + 1; e.n_mrd = TMO;
      return e;
    end
    e.n_mrd = fw + 1; e.n_irw = 1; e.n_pcw = 1;
    if (!is_legal(op)) begin
      e.is_trap = 1; e.cause = 1; e.lat = fw + 3;
    end else if (is_mem(op)) begin
      if (mw >= TMO) begin
        e.is_trap = 1; e.cause = 2; e.lat = pre + TMO + 1;
        if (op == OP_SW) e.n_mwr = TMO; else e.n_mrd += TMO;
      end else if (op == OP_SW) begin
        e.lat = pre + mw + 1; e.n_mwr = mw + 1; e.snap = 'h080;
      end else begin
        e.lat = pre + mw + 2; e.n_mrd += mw + 1; e.n_rw = 1;
        e.snap = (op == OP_LW) ? 'h400 : (op == OP_LH) ? 'h600 : 'h700;
      end
    end else begin
      case (op)
        OP_RTYPE: begin e.lat = fw + 4; e.n_rw = 1; e.snap = 'h800; end
        OP_ADDI:  begin e.lat = fw + 4; e.n_rw = 1; e.snap = 'h000; end
        OP_BEQ:   begin e.lat = fw + 3; e.n_pwc = 1; e.snap = 'h045; end
        default:  begin e.lat = fw + 3; e.n_pcw = 2; e.snap = 'h002; end
      endcase
    end
    return e;
  endfunction

  // Monitor: accumulates per-instruction activity, compares on retire/trap.
  int   m_cyc, c_mrd, c_mwr, c_rw, c_pcw, c_irw, c_pwc;
  bit   m_in_trap;
  exp_t m_e;
  always @(negedge clk) begin
    if (reset) begin
      m_cyc = 0; c_mrd = 0; c_mwr = 0; c_rw = 0; c_pcw = 0; c_irw = 0; c_pwc = 0;
      m_in_trap = 0;
    end else if (!m_in_trap) begin
      m_cyc++;
      c_mrd += int'(mem_read); c_mwr += int'(mem_write); c_rw += int'(reg_write);
      c_pcw += int'(pc_write); c_irw += int'(ir_write); c_pwc += int'(pc_write_cond);
      if (retire || trap) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          m_e = sbq.pop_front();
          chk("latency", m_cyc, m_e.lat);
          chk("trap", int'(trap), int'(m_e.is_trap));
          chk("trap_cause", int'(trap_cause), m_e.cause);
          chk("mem_read_cycles", c_mrd, m_e.n_mrd);
          chk("mem_write_cycles", c_mwr, m_e.n_mwr);
          chk("reg_write_cycles", c_rw, m_e.n_rw);
          chk("pc_write_cycles", c_pcw, m_e.n_pcw);
          chk("ir_write_cycles", c_irw, m_e.n_irw);
          chk("pc_write_cond_cycles", c_pwc, m_e.n_pwc);
          if (trap) begin
            chk("trap_ctrl_zero", int'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, half, half_unsigned, retire}), 0);
          end else begin
            chk("final_ctrl", int'({reg_dst, mem_to_reg, half, half_unsigned, i_or_d,
                alu_src_a, alu_src_b, alu_op, pc_source}), m_e.snap);
          end
        end
        if (trap) m_in_trap = 1;
        m_cyc = 0; c_mrd = 0; c_mwr = 0; c_rw = 0; c_pcw = 0; c_irw = 0; c_pwc = 0;
      end
    end
  end

  // Drives one instruction from the start of its FETCH cycle; resets after a trap.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    int   pre;
    bit   mem_op;
    e = model(op, fw, mw);
    sbq.push_back(e);
    mem_op = is_legal(op) && is_mem(op);
    pre = fw + 3;
    opcode = op;
    zero = 1'($urandom);
    for (int k = 1; k <= e.lat; k++) begin
      if (k <= fw) mem_ready = 1'b0;
      else if (k == fw + 1) mem_ready = 1'b1;
      else if (mem_op && k > pre && k <= pre + mw) mem_ready = 1'b0;
      else if (mem_op && k == pre + mw + 1) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    if (e.is_trap) begin
      repeat (2) begin
        mem_ready = 1'($urandom);
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  // Reset landing in MEM_RD of a lw: next cycle is a clean FETCH with no retire.
  task automatic run_abort();
    opcode = OP_LW;
    for (int k = 1; k <= 6; k++) begin
      mem_ready = (k == 1) ? 1'b1 : (k >= 4) ? 1'b0 : 1'($urandom);
      if (k == 6) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", int'(mem_read), 1);
    chk("abort_i_or_d", int'(i_or_d), 0);
    chk("abort_trap", int'(trap), 0);
    chk("abort_retire", int'(retire), 0);
    chk("abort_pc_write", int'(pc_write), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Second instance: HALF_EN=0, JUMP_EN=0, no timeout; fetch ready at once, mem waits in MEM_RD.
  task automatic nh_run(input logic [5:0] op, input int waits, output int lat,
                        output int trapped, output int cause);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    op2 = op;
    lat = 0; trapped = 0; cause = 0;
    for (int k = 1; k <= 200; k++) begin
      rdy2 = (k >= 4 && k < 4 + waits) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (trap2) begin lat = k; trapped = 1; cause = int'(tc2); break; end
      if (ret2)  begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst2 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops [8];
    logic [5:0] op;
    int fw, mw, lat, trapped, cause;
    legal_ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_LH, OP_LHU};
    reset = 1'b1; mem_ready = 1'b0; opcode = OP_RTYPE; zero = 1'b0;
    rst2 = 1'b1; rdy2 = 1'b0; op2 = OP_RTYPE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_read", int'(mem_read), 1);
    chk("reset_alu_src_b", int'(alu_src_b), 1);
    chk("reset_pc_write", int'(pc_write), 0);
    chk("reset_trap", int'(trap), 0);
    chk("reset_trap_cause", int'(trap_cause), 0);
    chk("reset_retire", int'(retire), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(OP_LW, 0, 0);
    run_instr(OP_LHU, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_RTYPE, 16, 0);
    run_instr(OP_ADDI, 15, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_LH, 2, 15);
    run_instr(OP_LW, 0, 16);
    run_instr(OP_SW, 1, 16);
    run_instr(6'b111111, 0, 0);
    run_abort();

    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(14, 17);
      mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(14, 17);
      run_instr(op, fw, mw);
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    nh_run(OP_LHU, 0, lat, trapped, cause);
    chk("nh_lhu_trap", trapped, 1);
    chk("nh_lhu_cause", cause, 1);
    chk("nh_lhu_lat", lat, 3);
    nh_run(OP_LH, 0, lat, trapped, cause);
    chk("nh_lh_trap", trapped, 1);
    nh_run(OP_J, 0, lat, trapped, cause);
    chk("nh_j_trap", trapped, 1);
    chk("nh_j_cause", cause, 1);
    nh_run(OP_LW, 40, lat, trapped, cause);
    chk("nh_lw_notrap", trapped, 0);
    chk("nh_lw_lat", lat, 45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
